// File: rtl/si5345_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : si5345_spi_master
// Purpose  : Register-level SPI master for the Si5345 jitter attenuator.
//            Turns single-byte read/write requests on a 16-bit register
//            address into Si5345 16-bit command frames (page select, set
//            address, write/read data). It remembers the current page, so
//            repeated accesses inside one page skip the two page frames.
// Ports    : clk_40m_i / reset_n_i   - 40 MHz clock, sync active-low reset
//            req_i, wr_i, addr_i,
//            wdata_i                 - request (latched while not busy)
//            busy_o, done_o, rdata_o - status, completion pulse, read byte
//            spi_sclk_o, spi_cs_n_o,
//            spi_mosi_o, spi_miso_i  - SPI mode 0 bus, MSB first
// Revision : 1.0 - initial release
// ============================================================================
module si5345_spi_master #(
    parameter int CLK_DIV = 4,   // SCLK half-period in clk cycles (>= 1)
    parameter int CS_GAP  = 4    // minimum CS high time between frames (>= 1)
) (
    input  logic        clk_40m_i,
    input  logic        reset_n_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  rdata_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_n_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(CS_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Frame word selection is combinational, so moving to the next frame
    // costs no extra cycle: CS_SETUP follows the accept or CS_GAP directly.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_CS_HOLD  = 3'd4,
        S_CS_GAP   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Frame k of an access. Without page frames the list starts at the
    // address frame, hence the +2 offset into the full four-frame list.
    function automatic logic [15:0] frame_word(input logic        pm,
                                               input logic [1:0]  idx,
                                               input logic        wr,
                                               input logic [15:0] addr,
                                               input logic [7:0]  wdata);
        logic [1:0] k;
        k = pm ? idx : (idx + 2'd2);
        case (k)
            2'd0:    frame_word = 16'h0001;
            2'd1:    frame_word = {8'h40, addr[15:8]};
            2'd2:    frame_word = {8'h00, addr[7:0]};
            default: frame_word = wr ? {8'h40, wdata} : 16'h8000;
        endcase
    endfunction

    state_t               r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]   r_div,       w_div_nxt;
    logic [3:0]           r_bit,       w_bit_nxt;
    logic [1:0]           r_frame,     w_frame_nxt;
    logic                 r_page_mode, w_page_mode_nxt;
    logic                 r_wr,        w_wr_nxt;
    logic [15:0]          r_addr,      w_addr_nxt;
    logic [7:0]           r_wdata,     w_wdata_nxt;
    logic [15:0]          r_tx,        w_tx_nxt;
    logic [7:0]           r_rx,        w_rx_nxt;
    logic [7:0]           r_rdata,     w_rdata_nxt;
    logic                 r_page_valid, w_page_valid_nxt;
    logic [7:0]           r_cur_page,  w_cur_page_nxt;
    logic                 r_sclk,      w_sclk_nxt;
    logic                 r_cs_n,      w_cs_n_nxt;
    logic                 r_mosi,      w_mosi_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_done,      w_done_nxt;

    logic                 w_page_miss;
    logic [1:0]           w_last_frame;
    logic [15:0]          w_first_word;
    logic [15:0]          w_next_word;

    assign w_page_miss  = !r_page_valid || (addr_i[15:8] != r_cur_page);
    assign w_last_frame = r_page_mode ? 2'd3 : 2'd1;
    assign w_first_word = frame_word(w_page_miss, 2'd0, wr_i, addr_i, wdata_i);
    assign w_next_word  = frame_word(r_page_mode, r_frame + 2'd1, r_wr, r_addr, r_wdata);

    always_comb begin
        w_state_nxt      = r_state;
        w_div_nxt        = r_div;
        w_bit_nxt        = r_bit;
        w_frame_nxt      = r_frame;
        w_page_mode_nxt  = r_page_mode;
        w_wr_nxt         = r_wr;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_tx_nxt         = r_tx;
        w_rx_nxt         = r_rx;
        w_rdata_nxt      = r_rdata;
        w_page_valid_nxt = r_page_valid;
        w_cur_page_nxt   = r_cur_page;
        w_sclk_nxt       = r_sclk;
        w_cs_n_nxt       = r_cs_n;
        w_mosi_nxt       = r_mosi;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;

        case (r_state)
            // DONE is not busy, so a request there starts the next access
            // back-to-back, exactly like IDLE.
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (req_i) begin
                    w_state_nxt     = S_CS_SETUP;
                    w_wr_nxt        = wr_i;
                    w_addr_nxt      = addr_i;
                    w_wdata_nxt     = wdata_i;
                    w_page_mode_nxt = w_page_miss;
                    w_frame_nxt     = 2'd0;
                    w_tx_nxt        = w_first_word;
                    w_mosi_nxt      = w_first_word[15];
                    w_cs_n_nxt      = 1'b0;
                    w_sclk_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_div_nxt       = c_DIV_LOAD;
                end
            end
            S_CS_SETUP: begin
                if (r_div == '0) begin
                    w_state_nxt = S_SHIFT_LO;
                    w_div_nxt   = c_DIV_LOAD;
                    w_bit_nxt   = 4'd15;
                end else begin
                    w_div_nxt   = r_div - c_CNT_ONE;
                end
            end
            S_SHIFT_LO: begin
                if (r_div == '0) begin
                    // Rising SCLK edge: capture MISO on the same clk edge.
                    w_state_nxt = S_SHIFT_HI;
                    w_sclk_nxt  = 1'b1;
                    w_rx_nxt    = {r_rx[6:0], spi_miso_i};
                    w_div_nxt   = c_DIV_LOAD;
                end else begin
                    w_div_nxt   = r_div - c_CNT_ONE;
                end
            end
            S_SHIFT_HI: begin
                if (r_div == '0) begin
                    w_sclk_nxt = 1'b0;
                    w_div_nxt  = c_DIV_LOAD;
                    if (r_bit == 4'd0) begin
                        w_state_nxt = S_CS_HOLD;
                    end else begin
                        // Falling SCLK edge: present the next bit.
                        w_state_nxt = S_SHIFT_LO;
                        w_bit_nxt   = r_bit - 4'd1;
                        w_tx_nxt    = {r_tx[14:0], 1'b0};
                        w_mosi_nxt  = r_tx[14];
                    end
                end else begin
                    w_div_nxt = r_div - c_CNT_ONE;
                end
            end
            S_CS_HOLD: begin
                if (r_div == '0) begin
                    w_state_nxt = S_CS_GAP;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_div_nxt   = c_GAP_LOAD;
                    // Second page frame finished: the device now sits on
                    // this page.
                    if (r_page_mode && (r_frame == 2'd1)) begin
                        w_page_valid_nxt = 1'b1;
                        w_cur_page_nxt   = r_addr[15:8];
                    end
                end else begin
                    w_div_nxt = r_div - c_CNT_ONE;
                end
            end
            S_CS_GAP: begin
                if (r_div == '0) begin
                    if (r_frame == w_last_frame) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        if (!r_wr) begin
                            w_rdata_nxt = r_rx;
                        end
                    end else begin
                        w_state_nxt = S_CS_SETUP;
                        w_frame_nxt = r_frame + 2'd1;
                        w_tx_nxt    = w_next_word;
                        w_mosi_nxt  = w_next_word[15];
                        w_cs_n_nxt  = 1'b0;
                        w_div_nxt   = c_DIV_LOAD;
                    end
                end else begin
                    w_div_nxt = r_div - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_40m_i) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= 4'd0;
            r_frame      <= 2'd0;
            r_page_mode  <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 8'h00;
            r_tx         <= 16'h0000;
            r_rx         <= 8'h00;
            r_rdata      <= 8'h00;
            r_page_valid <= 1'b0;
            r_cur_page   <= 8'h00;
            r_sclk       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_bit        <= w_bit_nxt;
            r_frame      <= w_frame_nxt;
            r_page_mode  <= w_page_mode_nxt;
            r_wr         <= w_wr_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_tx         <= w_tx_nxt;
            r_rx         <= w_rx_nxt;
            r_rdata      <= w_rdata_nxt;
            r_page_valid <= w_page_valid_nxt;
            r_cur_page   <= w_cur_page_nxt;
            r_sclk       <= w_sclk_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_mosi       <= w_mosi_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign rdata_o    = r_rdata;
    assign spi_sclk_o = r_sclk;
    assign spi_cs_n_o = r_cs_n;
    assign spi_mosi_o = r_mosi;

endmodule
`default_nettype wire
